// File: rtl/term_dma_writer.sv
// Text-terminal character writer: turns a character stream into video RAM writes,
// handling CR/LF/BS/FF, hardware scrolling via a top-row pointer, and a blinking cursor.
module term_dma_writer #(
  parameter int                 COLS      = 80,
  parameter int                 ROWS      = 25,
  parameter int                 ADR_W     = 11,
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  BLANK     = DATA_W'(8'h20),
  parameter int                 BLINK_DIV = 12_500_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_char_valid,
  input  logic [DATA_W-1:0] i_char_data,
  output logic              o_char_ready,
  input  logic              i_cursor_en,
  output logic [DATA_W-1:0] o_vram_data,
  output logic [ADR_W-1:0]  o_vram_adr,
  output logic              o_vram_we,
  output logic [ADR_W-1:0]  o_cursor_adr,
  output logic              o_cursor_on,
  output logic [ADR_W-1:0]  o_top_row
);

  localparam logic [1:0] CLR_SCR  = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] CLR_LINE = 2'd2;

  localparam logic [ADR_W-1:0]  A_COLS     = ADR_W'(COLS);
  localparam logic [ADR_W-1:0]  LAST_COL   = ADR_W'(COLS - 1);
  localparam logic [ADR_W-1:0]  LAST_ROW   = ADR_W'(ROWS - 1);
  localparam logic [ADR_W-1:0]  LAST_CELL  = ADR_W'(COLS * ROWS - 1);
  localparam logic [31:0]       BLINK_LAST = 32'(BLINK_DIV - 1);
  localparam logic [DATA_W-1:0] C_BS = DATA_W'(8'h08);
  localparam logic [DATA_W-1:0] C_LF = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] C_FF = DATA_W'(8'h0C);
  localparam logic [DATA_W-1:0] C_CR = DATA_W'(8'h0D);

  logic [1:0]        state_q, state_d;
  logic [ADR_W-1:0]  col_q, col_d, row_q, row_d, top_q, top_d;
  logic [ADR_W-1:0]  phys_row_q, phys_row_d;
  logic [ADR_W-1:0]  row_base_q, row_base_d, top_base_q, top_base_d;
  logic [ADR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [ADR_W-1:0]  cursor_adr_q, cursor_adr_d;
  logic [ADR_W-1:0]  vram_adr_q, vram_adr_d;
  logic [DATA_W-1:0] vram_data_q, vram_data_d;
  logic              vram_we_q, vram_we_d;
  logic [31:0]       blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic              do_nl;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    top_d       = top_q;
    phys_row_d  = phys_row_q;
    row_base_d  = row_base_q;
    top_base_d  = top_base_q;
    clr_cnt_d   = clr_cnt_q;
    vram_we_d   = 1'b0;
    vram_adr_d  = vram_adr_q;
    vram_data_d = vram_data_q;
    do_nl       = 1'b0;

    case (state_q)
      CLR_SCR: begin
        vram_we_d   = 1'b1;
        vram_adr_d  = clr_cnt_q;
        vram_data_d = BLANK;
        clr_cnt_d   = (clr_cnt_q == LAST_CELL) ? '0 : clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_CELL) state_d = IDLE;
      end
      CLR_LINE: begin
        // row_base already points at the freshly exposed bottom row.
        vram_we_d   = 1'b1;
        vram_adr_d  = row_base_q + clr_cnt_q;
        vram_data_d = BLANK;
        clr_cnt_d   = (clr_cnt_q == LAST_COL) ? '0 : clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_COL) state_d = IDLE;
      end
      IDLE: begin
        if (i_char_valid) begin
          case (i_char_data)
            C_BS: if (col_q != '0) col_d = col_q - 1'b1;
            C_CR: col_d = '0;
            C_LF: do_nl = 1'b1;
            C_FF: begin
              col_d      = '0;
              row_d      = '0;
              top_d      = '0;
              phys_row_d = '0;
              row_base_d = '0;
              top_base_d = '0;
              clr_cnt_d  = '0;
              state_d    = CLR_SCR;
            end
            default: begin
              vram_we_d   = 1'b1;
              vram_adr_d  = row_base_q + col_q;
              vram_data_d = i_char_data;
              if (col_q == LAST_COL) do_nl = 1'b1;
              else                   col_d = col_q + 1'b1;
            end
          endcase
        end
      end
      default: state_d = CLR_SCR;
    endcase

    if (do_nl) begin
      col_d = '0;
      if (row_q != LAST_ROW) begin
        row_d      = row_q + 1'b1;
        phys_row_d = (phys_row_q == LAST_ROW) ? '0 : phys_row_q + 1'b1;
        row_base_d = (phys_row_q == LAST_ROW) ? '0 : row_base_q + A_COLS;
      end else begin
        // Scrolling: the old top physical row becomes the new bottom row.
        top_d      = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
        top_base_d = (top_q == LAST_ROW) ? '0 : top_base_q + A_COLS;
        phys_row_d = top_q;
        row_base_d = top_base_q;
        clr_cnt_d  = '0;
        state_d    = CLR_LINE;
      end
    end
  end

  always_comb begin
    cursor_adr_d = row_base_q + col_q;
    blink_cnt_d  = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    phase_d      = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= CLR_SCR;
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '0;
      phys_row_q   <= '0;
      row_base_q   <= '0;
      top_base_q   <= '0;
      clr_cnt_q    <= '0;
      cursor_adr_q <= '0;
      vram_adr_q   <= '0;
      vram_data_q  <= '0;
      vram_we_q    <= 1'b0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      phys_row_q   <= phys_row_d;
      row_base_q   <= row_base_d;
      top_base_q   <= top_base_d;
      clr_cnt_q    <= clr_cnt_d;
      cursor_adr_q <= cursor_adr_d;
      vram_adr_q   <= vram_adr_d;
      vram_data_q  <= vram_data_d;
      vram_we_q    <= vram_we_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
    end
  end

  assign o_char_ready = (state_q == IDLE);
  assign o_vram_we    = vram_we_q;
  assign o_vram_adr   = vram_adr_q;
  assign o_vram_data  = vram_data_q;
  assign o_cursor_adr = cursor_adr_q;
  assign o_cursor_on  = i_cursor_en & phase_q & (state_q == IDLE);
  assign o_top_row    = top_q;

endmodule

// File: tb/tb_term_dma_writer.sv
// Directed bench for term_dma_writer: clears, printing, control codes, scrolling,
// cursor blink and reset abort, with hand-computed expected addresses.
module tb_term_dma_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        cursor_en;
  logic [7:0]  vram_data;
  logic [10:0] vram_adr;
  logic        vram_we;
  logic [10:0] cursor_adr;
  logic        cursor_on;
  logic [10:0] top_row;

  int n_cmp = 0;
  int n_mis = 0;

  term_dma_writer #(.BLINK_DIV(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_char_valid (char_valid),
    .i_char_data  (char_data),
    .o_char_ready (char_ready),
    .i_cursor_en  (cursor_en),
    .o_vram_data  (vram_data),
    .o_vram_adr   (vram_adr),
    .o_vram_we    (vram_we),
    .o_cursor_adr (cursor_adr),
    .o_cursor_on  (cursor_on),
    .o_top_row    (top_row)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    char_valid = 1'b1;
    char_data  = c;
    tick();
    char_valid = 1'b0;
    char_data  = 8'($urandom);
  endtask

  // n consecutive BLANK writes from first_adr; ready must rise only with the last one.
  task automatic expect_burst(input int n, input int first_adr, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!(vram_we === 1'b1 && vram_adr === 11'(first_adr + i) &&
            vram_data === 8'h20 && char_ready === (i == n - 1))) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Back-to-back printable stream starting at address first_adr.
  task automatic expect_stream(input int n, input int first_adr, input string tag);
    int bad = 0;
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      c = 8'h41 + 8'(i % 26);
      char_valid = 1'b1;
      char_data  = c;
      tick();
      if (!(vram_we === 1'b1 && vram_adr === 11'(first_adr + i) && vram_data === c)) bad++;
    end
    char_valid = 1'b0;
    check(tag, bad, 0);
  endtask

  task automatic send_lfs(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      send(8'h0A);
      if (vram_we !== 1'b0 || char_ready !== 1'b1) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int on_cnt;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    cursor_en  = 1'b0;
    repeat (3) tick();
    check("rst_ready", char_ready, 0);
    check("rst_we", vram_we, 0);
    check("rst_data", vram_data, 0);
    check("rst_adr", vram_adr, 0);
    check("rst_cursor", cursor_adr, 0);
    check("rst_top", top_row, 0);
    cursor_en = 1'b1;
    #1;
    check("rst_cursor_on", cursor_on, 0);
    cursor_en = 1'b0;

    rst_n = 1'b1;
    expect_burst(2000, 0, "init_clear");
    tick();
    check("post_clear_we", vram_we, 0);
    check("post_clear_ready", char_ready, 1);
    check("post_clear_cursor", cursor_adr, 0);

    send(8'h41);
    check("A_we", vram_we, 1);
    check("A_adr", vram_adr, 0);
    check("A_data", vram_data, 8'h41);
    tick();
    check("A_we_drop", vram_we, 0);
    check("A_cursor", cursor_adr, 1);

    send(8'h0D);
    check("cr_no_write", vram_we, 0);
    tick();
    check("cr_cursor", cursor_adr, 0);

    expect_stream(80, 0, "row0_stream");
    check("row0_ready", char_ready, 1);
    tick();
    check("row0_wrap_cursor", cursor_adr, 80);

    send(8'h08);
    check("bs_col0_no_write", vram_we, 0);
    tick();
    check("bs_col0_cursor", cursor_adr, 80);

    expect_stream(37, 80, "col37_stream");
    tick();
    check("col37_cursor", cursor_adr, 117);
    send(8'h0D);
    check("cr37_no_write", vram_we, 0);
    tick();
    check("cr37_cursor", cursor_adr, 80);

    expect_stream(3, 80, "bs_prep_stream");
    send(8'h08);
    check("bs_no_write", vram_we, 0);
    tick();
    check("bs_cursor", cursor_adr, 82);

    send_lfs(23, "lf_to_row24");
    tick();
    check("row24_cursor", cursor_adr, 1920);
    send(8'h5A);
    check("row24_adr", vram_adr, 1920);

    send(8'h0A);
    check("scroll_no_write", vram_we, 0);
    check("scroll_ready_low", char_ready, 0);
    check("scroll_top", top_row, 1);
    expect_burst(80, 0, "scroll_clear_line");
    tick();
    check("scroll_cursor", cursor_adr, 0);

    send(8'h51);
    check("post_scroll_adr", vram_adr, 0);
    expect_stream(78, 1, "bottom_stream");
    send(8'h7A);
    check("col79_adr", vram_adr, 79);
    check("col79_data", vram_data, 8'h7A);
    check("col79_ready_low", char_ready, 0);
    check("col79_top", top_row, 2);
    expect_burst(80, 80, "wrap_scroll_clear");
    tick();
    check("wrap_scroll_cursor", cursor_adr, 80);

    cursor_en = 1'b1;
    on_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (cursor_on === 1'b1) on_cnt++;
    end
    check("blink_duty", on_cnt, 16);
    cursor_en = 1'b0;
    #1;
    check("cursor_disabled", cursor_on, 0);

    send(8'h0C);
    check("ff_no_write", vram_we, 0);
    check("ff_ready_low", char_ready, 0);
    check("ff_top", top_row, 0);
    expect_burst(2000, 0, "ff_clear");
    tick();
    check("ff_cursor", cursor_adr, 0);

    send_lfs(24, "lf_to_row24_b");
    send(8'h0A);
    check("scroll2_top", top_row, 1);
    repeat (5) tick();
    check("mid_line_we", vram_we, 1);
    check("mid_line_adr", vram_adr, 4);
    rst_n = 1'b0;
    #1;
    check("abort_we", vram_we, 0);
    check("abort_ready", char_ready, 0);
    check("abort_top", top_row, 0);
    repeat (2) tick();
    check("abort_hold_we", vram_we, 0);
    rst_n = 1'b1;
    expect_burst(2000, 0, "restart_clear");
    tick();
    check("restart_ready", char_ready, 1);
    check("restart_cursor", cursor_adr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/term_dma_writer.md
TERM_DMA_WRITER -- requirements
Module: term_dma_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per text row.
REQ-002 SHALL have parameter ROWS, default 25, text rows per screen.
REQ-003 SHALL have parameter ADR_W, default 11, VRAM/cursor address width; requires COLS*ROWS <= 2**ADR_W.
REQ-004 SHALL have parameter DATA_W, default 8, character code width.
REQ-005 SHALL have parameter BLANK, default 8'h20, fill code for clears.
REQ-006 SHALL have parameter BLINK_DIV, default 12_500_000, clock cycles per cursor blink half-period.
REQ-007 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-008 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port i_char_valid  input  1  character offered.
REQ-010 SHALL have port i_char_data  input  DATA_W  character or control code.
REQ-011 SHALL have port o_char_ready  output  1  block accepts a character this cycle.
REQ-012 SHALL have port i_cursor_en  input  1  cursor display enable.
REQ-013 SHALL have port o_vram_data  output  DATA_W  write data to video RAM.
REQ-014 SHALL have port o_vram_adr  output  ADR_W  write address to video RAM.
REQ-015 SHALL have port o_vram_we  output  1  one-cycle write strobe, active high.
REQ-016 SHALL have port o_cursor_adr  output  ADR_W  physical VRAM address of the cursor cell.
REQ-017 SHALL have port o_cursor_on  output  1  cursor currently visible.
REQ-018 SHALL have port o_top_row  output  ADR_W  physical row displayed at screen top, for scroll-aware display fetch.

Function
REQ-019 SHALL implement FSM states CLR_SCR, IDLE, CLR_LINE; o_char_ready SHALL be 1 only in IDLE.
REQ-020 SHALL accept a character on a cycle with i_char_valid=1 and o_char_ready=1; i_char_data SHALL be sampled that cycle.
REQ-021 SHALL track logical col (0..COLS-1), logical row (0..ROWS-1), and top (0..ROWS-1); phys_row = (top+row) mod ROWS; address = phys_row*COLS + col, computed without a multiplier (incremental row base).
REQ-022 SHALL, for a printable code (anything other than 0x08/0x0A/0x0C/0x0D), drive o_vram_we=1 with o_vram_data=code and o_vram_adr=current cell on the cycle after acceptance, then advance col.
REQ-023 SHALL, when a printable write lands at col=COLS-1, perform a newline instead of incrementing col.
REQ-024 SHALL treat 0x0D (CR) as col<=0, with no write.
REQ-025 SHALL treat 0x0A (LF) as a newline: col<=0; if row<ROWS-1, row++ and remain in IDLE.
REQ-026 SHALL, on a newline with row=ROWS-1, perform a scroll: top<=(top+1) mod ROWS, row unchanged, then enter CLR_LINE.
REQ-027 SHALL, in CLR_LINE, write BLANK to the COLS cells of the new bottom physical row in ascending column order, one per cycle, then return to IDLE; o_char_ready SHALL stay 0 for exactly COLS cycles.
REQ-028 SHALL treat 0x08 (BS) as col<=col-1 when col>0 and leave col at 0 otherwise, with no write and no row change.
REQ-029 SHALL treat 0x0C (FF) as col<=0, row<=0, top<=0, then enter CLR_SCR.
REQ-030 SHALL, in CLR_SCR, write BLANK to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, then enter IDLE.
REQ-031 SHALL drive o_cursor_adr as the registered address of (phys_row, col), updated the cycle after any cursor change.
REQ-032 SHALL run a blink counter that wraps at BLINK_DIV-1 and toggles a phase bit; o_cursor_on = i_cursor_en AND phase AND (state==IDLE).
REQ-033 SHALL keep o_vram_we=0 on every cycle without a write; no write SHALL ever target an address >= COLS*ROWS.
REQ-034 SHALL ignore i_char_data whenever o_char_ready=0; no character SHALL be lost or duplicated across back-to-back accepts.

Reset
REQ-035 SHALL, while i_rst_n=0, hold o_char_ready=0, o_vram_we=0, o_vram_data=0, o_vram_adr=0, o_cursor_adr=0, o_cursor_on=0, o_top_row=0, col=row=top=0, and the blink counter and phase at 0.
REQ-036 SHALL enter CLR_SCR on the first clock after reset release; an assertion of reset mid-clear or mid-write SHALL abort immediately with no further strobe.

Verification
REQ-037 SHALL cover: release reset (defaults) -> 2000 consecutive we pulses at addresses 0..1999 with data 0x20, then o_char_ready=1 and o_cursor_adr=0.
REQ-038 SHALL cover: send "A" (0x41) -> one write of 0x41 at address 0; o_cursor_adr=1.
REQ-039 SHALL cover: 80 printable characters from col 0, row 0 -> last write at address 79; cursor at address 80 (row 1, col 0).
REQ-040 SHALL cover: cursor at row 24, send LF -> o_top_row=1; writes of 0x20 at addresses 0..79; ready low for 80 cycles; o_cursor_adr=0 (phys row 0).
REQ-041 SHALL cover: BS at col 0 -> no write and cursor unchanged; CR at col 37 -> cursor col 0 with no write.
REQ-042 SHALL cover: reset asserted during CLR_LINE -> o_vram_we=0 immediately; after release a full 2000-cell clear restarts from address 0.
